// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg: shared types and constants for the clock frequency meter
// Contents:
//   meas_state_t     measurement FSM states (IDLE, GATE, DONE)
//   DEF_GATE_CYCLES  default gate window length in sys_clk cycles
//   DEF_CNT_W        default result counter width
//   gate_cnt_w()     width of a down-counter that must hold gate_cycles-1
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        DONE
    } meas_state_t;

    localparam int DEF_GATE_CYCLES = 1000;
    localparam int DEF_CNT_W       = 16;

    function automatic int gate_cnt_w(input int gate_cycles);
        return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// sync_rise_det: 2-FF synchronizer plus history register for rising-edge detect
// Ports:
//   sys_clk    in   sampling clock
//   sys_rst_n  in   asynchronous active-low reset, clears all stages to 0
//   async_in   in   asynchronous level to condition
//   s2         out  synchronized level
//   rise       out  one-cycle pulse on a synchronized 0->1 transition
module sync_rise_det (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic async_in,
    output logic s2,
    output logic rise
);

    logic s1;
    logic prev;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

endmodule

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts rising edges (and optionally high cycles) of a slow clock over a gate window
// Parameters:
//   GATE_CYCLES  gate window length in sys_clk cycles (>= 2)
//   CNT_W        result counter width
// Ports:
//   sys_clk    in   system clock, the only clock
//   sys_rst_n  in   asynchronous active-low reset
//   clk_in     in   clock under measurement, sampled as asynchronous data
//   start      in   single-cycle measurement request, honoured only when idle
//   busy       out  gate window open
//   done       out  one-cycle pulse, results valid
//   edge_cnt   out  rising edges seen in the last window
//   high_cnt   out  sys_clk cycles clk_in was high in the last window
//   overflow   out  a counter saturated in the last window
// Build option:
//   CLK_METER_DUTY_EN  defined: high-time accumulator is built; undefined: high_cnt is 0
module clk_freq_meter
    import clk_meas_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             overflow
);

    localparam int               GW        = gate_cnt_w(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    meas_state_t      state;
    meas_state_t      state_nxt;
    logic [GW-1:0]    gate_cnt;
    logic             s2;
    logic             rise;
    logic             gate_entry;
    logic             gate_last;
    logic [CNT_W-1:0] edge_acc;
    logic [CNT_W-1:0] edge_acc_nxt;
    logic             edge_sat;
    logic             high_sat;
    logic             sticky;
    logic             ovf_nxt;

    sync_rise_det u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .async_in  (clk_in),
        .s2        (s2),
        .rise      (rise)
    );

    always_comb begin
        state_nxt  = state;
        gate_entry = 1'b0;
        gate_last  = 1'b0;
        unique case (state)
            IDLE: begin
                gate_entry = start;
                state_nxt  = start ? GATE : IDLE;
            end
            GATE: begin
                gate_last = (gate_cnt == '0);
                state_nxt = gate_last ? DONE : GATE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // A saturation attempt is an increment request while already at max;
    // the accumulator holds and the sticky flag records it.
    assign edge_sat     = rise && (edge_acc == CNT_MAX);
    assign edge_acc_nxt = edge_acc + CNT_W'(rise & ~edge_sat);
    assign ovf_nxt      = sticky | edge_sat | high_sat;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gate_cnt <= '0;
            edge_acc <= '0;
            sticky   <= 1'b0;
        end else if (gate_entry) begin
            gate_cnt <= GATE_LOAD;
            edge_acc <= '0;
            sticky   <= 1'b0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt - 1'b1;
            edge_acc <= edge_acc_nxt;
            sticky   <= ovf_nxt;
        end
    end

    // The final sample is folded in on the same edge that publishes, so the
    // outputs take the next-value of the accumulators rather than their state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            edge_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            busy <= (state_nxt == GATE);
            done <= gate_last;
            if (gate_last) begin
                edge_cnt <= edge_acc_nxt;
                overflow <= ovf_nxt;
            end
        end
    end

`ifdef CLK_METER_DUTY_EN
    logic [CNT_W-1:0] high_acc;
    logic [CNT_W-1:0] high_acc_nxt;

    assign high_sat     = s2 && (high_acc == CNT_MAX);
    assign high_acc_nxt = high_acc + CNT_W'(s2 & ~high_sat);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            high_acc <= '0;
            high_cnt <= '0;
        end else begin
            if (gate_entry)         high_acc <= '0;
            else if (state == GATE) high_acc <= high_acc_nxt;
            if (gate_last)          high_cnt <= high_acc_nxt;
        end
    end
`else
    logic unused_s2;

    assign unused_s2 = s2;
    assign high_sat  = 1'b0;
    assign high_cnt  = '0;
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter: randomized self-checking bench for clk_freq_meter (16-bit and 8-bit counter instances)
module tb_clk_freq_meter;

    localparam int G = 1000;

    typedef struct {
        string name;
        int    mode;
        bit    lvl;
        int    per;
        int    high;
        bit    extra;
        int    known_a;
        int    known_b;
    } cfg_t;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        clk_in    = 1'b0;
    logic        start     = 1'b0;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [15:0] edge_a, high_a;
    logic [7:0]  edge_b, high_b;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit w [0:65535];
    int wmode  = 2;
    bit wconst = 1'b0;
    int wper   = 5;
    int whigh  = 2;
    int wph    = 0;

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(16)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_in(clk_in), .start(start),
        .busy(busy_a), .done(done_a), .edge_cnt(edge_a), .high_cnt(high_a), .overflow(ovf_a)
    );

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_in(clk_in), .start(start),
        .busy(busy_b), .done(done_b), .edge_cnt(edge_b), .high_cnt(high_b), .overflow(ovf_b)
    );

    always #5 sys_clk = ~sys_clk;

    // Phase-locked waveform source: clk_in changes 1 time unit after each
    // posedge, and w[n] records the level held throughout cycle n.
    always @(posedge sys_clk) begin
        cyc++;
        #1;
        case (wmode)
            0:       clk_in = wconst;
            1:       clk_in = ((cyc + wper - wph) % wper) < whigh;
            default: clk_in = 1'($urandom_range(0, 1));
        endcase
        if (cyc < 65536) w[cyc] = clk_in;
    end

    // Reference: the synchronized level in cycle c is the input level of
    // cycle c-2, so a window starting after cycle t sees samples
    // c = t+1 .. t+G, an edge wherever w[c-2]=1 and w[c-3]=0.
    function automatic void model(input int t, input int width, output int e, output int h, output bit o);
        int ne = 0;
        int nh = 0;
        int mx = (1 << width) - 1;
        for (int c = t + 1; c <= t + G; c++) begin
            ne += (w[c-2] && !w[c-3]) ? 1 : 0;
            nh += w[c-2] ? 1 : 0;
        end
        e = (ne > mx) ? mx : ne;
`ifdef CLK_METER_DUTY_EN
        h = (nh > mx) ? mx : nh;
        o = (ne > mx) || (nh > mx);
`else
        h = 0;
        o = (ne > mx);
`endif
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic wait_done(output int td);
        td = -1;
        for (int i = 0; i < G + 40; i++) begin
            if (done_a === 1'b1) begin
                td = cyc;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bit seen;
        wmode     = 2;
        sys_rst_n = 1'b0;
        repeat (6) step();
        vectors++;
        if ({busy_a, done_a, edge_a, high_a, ovf_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got %h expected 0", {busy_a, done_a, edge_a, high_a, ovf_a});
        end
        vectors++;
        if ({busy_b, done_b, edge_b, high_b, ovf_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got %h expected 0", {busy_b, done_b, edge_b, high_b, ovf_b});
        end
        sys_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen |= busy_a | busy_b | done_a | done_b;
            step();
        end
        vectors++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got busy/done %b expected 0", seen);
        end
    endtask

    task automatic test_windows();
        cfg_t tbl[$];
        tbl.push_back('{"div5",   1, 1'b0, 5,  2, 1'b0, 200, 200});
        tbl.push_back('{"duty10", 1, 1'b0, 10, 5, 1'b0, 100, 100});
        tbl.push_back('{"const1", 0, 1'b1, 1,  0, 1'b0, 0,   0});
        tbl.push_back('{"const0", 0, 1'b0, 1,  0, 1'b0, 0,   0});
        tbl.push_back('{"div2",   1, 1'b0, 2,  1, 1'b0, 500, 255});
        tbl.push_back('{"div8",   1, 1'b0, 8,  4, 1'b0, 125, 125});
        tbl.push_back('{"ignore", 1, 1'b0, 7,  3, 1'b1, -1,  -1});
        for (int k = 0; k < tbl.size() + 6; k++) begin
            cfg_t        c;
            int          t0, td, ea, ha, eb, hb;
            bit          oa, ob;
            logic        bf, bd, db, da, go_a, go_b;
            logic [15:0] ge_a, gh_a;
            logic [7:0]  ge_b, gh_b;
            if (k < tbl.size()) begin
                c = tbl[k];
            end else begin
                c.name    = (k < tbl.size() + 4) ? "rand_per" : "rand_bits";
                c.mode    = (k < tbl.size() + 4) ? 1 : 2;
                c.lvl     = 1'b0;
                c.per     = $urandom_range(2, 24);
                c.high    = $urandom_range(1, c.per - 1);
                c.extra   = 1'b0;
                c.known_a = -1;
                c.known_b = -1;
            end
            wmode  = c.mode;
            wconst = c.lvl;
            wper   = c.per;
            whigh  = c.high;
            wph    = $urandom_range(0, c.per - 1);
            repeat (6) step();
            start = 1'b1;
            t0    = cyc;
            step();
            start = 1'b0;
            bf    = busy_a & busy_b;
            if (c.extra) begin
                repeat (100) step();
                start = 1'b1;
                step();
                start = 1'b0;
            end
            wait_done(td);
            bd   = busy_a | busy_b;
            db   = done_b;
            ge_a = edge_a; gh_a = high_a; go_a = ovf_a;
            ge_b = edge_b; gh_b = high_b; go_b = ovf_b;
            step();
            da = done_a | done_b;
            model(t0, 16, ea, ha, oa);
            model(t0, 8, eb, hb, ob);
            vectors++;
            if (td !== t0 + G + 1) begin errors++; $display("FAIL %s latency: got %0d expected %0d", c.name, td - t0, G + 1); end
            vectors++;
            if (db !== 1'b1) begin errors++; $display("FAIL %s done_b: got %b expected 1", c.name, db); end
            vectors++;
            if (bf !== 1'b1) begin errors++; $display("FAIL %s busy_start: got %b expected 1", c.name, bf); end
            vectors++;
            if (bd !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b expected 0", c.name, bd); end
            vectors++;
            if (da !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b expected 0", c.name, da); end
            vectors++;
            if (ge_a !== 16'(ea)) begin errors++; $display("FAIL %s edge_a: got %0d expected %0d", c.name, ge_a, ea); end
            vectors++;
            if (gh_a !== 16'(ha)) begin errors++; $display("FAIL %s high_a: got %0d expected %0d", c.name, gh_a, ha); end
            vectors++;
            if (go_a !== oa) begin errors++; $display("FAIL %s ovf_a: got %b expected %b", c.name, go_a, oa); end
            vectors++;
            if (ge_b !== 8'(eb)) begin errors++; $display("FAIL %s edge_b: got %0d expected %0d", c.name, ge_b, eb); end
            vectors++;
            if (gh_b !== 8'(hb)) begin errors++; $display("FAIL %s high_b: got %0d expected %0d", c.name, gh_b, hb); end
            vectors++;
            if (go_b !== ob) begin errors++; $display("FAIL %s ovf_b: got %b expected %b", c.name, go_b, ob); end
            if (c.known_a >= 0) begin
                vectors++;
                if (ge_a !== 16'(c.known_a)) begin errors++; $display("FAIL %s edge_a_nominal: got %0d expected %0d", c.name, ge_a, c.known_a); end
                vectors++;
                if (ge_b !== 8'(c.known_b)) begin errors++; $display("FAIL %s edge_b_nominal: got %0d expected %0d", c.name, ge_b, c.known_b); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   t0, td, t1, td2, ea, ha;
        bit   oa;
        logic bf;
        wmode = 1;
        wper  = 4;
        whigh = 2;
        wph   = $urandom_range(0, 3);
        repeat (6) step();
        start = 1'b1;
        t0    = cyc;
        step();
        start = 1'b0;
        wait_done(td);
        start = 1'b1;
        step();
        t1 = cyc;
        step();
        start = 1'b0;
        bf    = busy_a;
        wait_done(td2);
        model(t1, 16, ea, ha, oa);
        vectors++;
        if (td !== t0 + G + 1) begin errors++; $display("FAIL b2b first_latency: got %0d expected %0d", td - t0, G + 1); end
        vectors++;
        if (td2 !== t1 + G + 1) begin errors++; $display("FAIL b2b restart_latency: got %0d expected %0d", td2 - t1, G + 1); end
        vectors++;
        if (bf !== 1'b1) begin errors++; $display("FAIL b2b restart_busy: got %b expected 1", bf); end
        vectors++;
        if (edge_a !== 16'(ea)) begin errors++; $display("FAIL b2b edge_a: got %0d expected %0d", edge_a, ea); end
        vectors++;
        if (ovf_a !== oa) begin errors++; $display("FAIL b2b ovf_a: got %b expected %b", ovf_a, oa); end
    endtask

    task automatic test_abort();
        int   t0, td, ea, ha, eb, hb;
        bit   oa, ob;
        logic seen;
        wmode = 1;
        wper  = 5;
        whigh = 3;
        wph   = $urandom_range(0, 4);
        repeat (6) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (300) step();
        sys_rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy_a, done_a, edge_a, high_a, ovf_a, busy_b, done_b, edge_b, high_b, ovf_b} !== '0) begin
            errors++;
            $display("FAIL abort_reset: got %h expected 0",
                     {busy_a, done_a, edge_a, high_a, ovf_a, busy_b, done_b, edge_b, high_b, ovf_b});
        end
        repeat (3) step();
        sys_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < G + 20; i++) begin
            seen |= done_a | done_b;
            step();
        end
        vectors++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", seen); end
        vectors++;
        if ({edge_a, edge_b} !== '0) begin errors++; $display("FAIL abort_no_partial: got %h expected 0", {edge_a, edge_b}); end
        start = 1'b1;
        t0    = cyc;
        step();
        start = 1'b0;
        wait_done(td);
        model(t0, 16, ea, ha, oa);
        model(t0, 8, eb, hb, ob);
        vectors++;
        if (td !== t0 + G + 1) begin errors++; $display("FAIL fresh latency: got %0d expected %0d", td - t0, G + 1); end
        vectors++;
        if (edge_a !== 16'(ea)) begin errors++; $display("FAIL fresh edge_a: got %0d expected %0d", edge_a, ea); end
        vectors++;
        if (high_a !== 16'(ha)) begin errors++; $display("FAIL fresh high_a: got %0d expected %0d", high_a, ha); end
        vectors++;
        if (edge_b !== 8'(eb)) begin errors++; $display("FAIL fresh edge_b: got %0d expected %0d", edge_b, eb); end
        vectors++;
        if (ovf_b !== ob) begin errors++; $display("FAIL fresh ovf_b: got %b expected %b", ovf_b, ob); end
    endtask

    initial begin
        test_reset();
        test_windows();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
